// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin WISHBONE arbiter.
// NUM_M masters share one slave port. One master is granted per bus cycle.
// Its request is steered to the slave, and ack/err go back to that master only.
// A watchdog ends any cycle that the slave never acknowledges.
module wb_rr_arbiter #(
  parameter int NUM_M   = 4,
  parameter int ADR_W   = 26,
  parameter int DAT_W   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_M-1:0]       m_cyc_i,
  input  logic [NUM_M-1:0]       m_stb_i,
  input  logic [NUM_M-1:0]       m_we_i,
  input  logic [NUM_M*ADR_W-1:0] m_adr_i,
  input  logic [NUM_M*DAT_W-1:0] m_dat_i,
  output logic [NUM_M-1:0]       m_ack_o,
  output logic [NUM_M-1:0]       m_err_o,
  output logic [DAT_W-1:0]       m_dat_o,
  output logic [NUM_M-1:0]       gnt_o,
  output logic                   busy_o,
  output logic                   s_cyc_o,
  output logic                   s_stb_o,
  output logic                   s_we_o,
  output logic                   s_taga_o,
  output logic [ADR_W-1:0]       s_adr_o,
  output logic [DAT_W-1:0]       s_dat_o,
  input  logic                   s_ack_i,
  input  logic [DAT_W-1:0]       s_dat_i
);

  localparam int PTR_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [NUM_M-1:0] gnt_q, gnt_d;
  logic [7:0]       wdog_q, wdog_d;

  logic [NUM_M-1:0] req_s;
  logic [NUM_M-1:0] pick_s;
  logic             found_s;
  logic [PTR_W-1:0] gidx_s;
  logic             active_s;
  logic             cyc_g_s;
  logic             tmo_s;

  // Convert the one-hot grant into a binary master index.
  function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [NUM_M-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_M; i++) begin
      idx = idx | (oh[i] ? PTR_W'(i) : '0);
    end
    return idx;
  endfunction

  // Index of the master after idx, wrapping at NUM_M.
  function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] idx);
    logic [PTR_W-1:0] nxt;
    if (int'(idx) >= NUM_M - 1) begin
      nxt = '0;
    end else begin
      nxt = idx + PTR_W'(1);
    end
    return nxt;
  endfunction

  assign req_s    = m_cyc_i & m_stb_i;
  assign gidx_s   = onehot_to_idx(gnt_q);
  assign active_s = (state_q == ST_ACTIVE);
  // Abort wins over ack, and ack wins over a watchdog expiry in the same cycle.
  assign cyc_g_s  = |(m_cyc_i & gnt_q);
  assign tmo_s    = active_s & cyc_g_s & ~s_ack_i & (wdog_q == WDOG_LAST);

  // Round-robin pick: the first requester at or after ptr, wrapping around.
  always_comb begin
    pick_s  = '0;
    found_s = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      logic [PTR_W-1:0] cand;
      cand = PTR_W'((int'(ptr_q) + i) % NUM_M);
      if (!found_s && req_s[cand]) begin
        pick_s[cand] = 1'b1;
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state logic for the grant FSM, the pointer and the watchdog.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    wdog_d  = wdog_q;
    case (state_q)
      ST_IDLE: begin
        wdog_d = 8'd0;
        if (found_s) begin
          gnt_d   = pick_s;
          state_d = ST_ACTIVE;
        end else begin
          gnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (!cyc_g_s || s_ack_i || tmo_s) begin
          state_d = ST_RELEASE;
        end else begin
          wdog_d  = wdog_q + 8'd1;
          state_d = ST_ACTIVE;
        end
      end
      ST_RELEASE: begin
        ptr_d   = next_idx(gidx_s);
        wdog_d  = 8'd0;
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        ptr_d   = '0;
        gnt_d   = '0;
        wdog_d  = 8'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state, round-robin pointer, registered grant and watchdog.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      wdog_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      wdog_q  <= wdog_d;
    end
  end

  // Steer the granted master's request onto the slave port while ACTIVE.
  always_comb begin
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    if (active_s) begin
      for (int i = 0; i < NUM_M; i++) begin
        s_we_o  = s_we_o | (gnt_q[i] & m_we_i[i]);
        s_adr_o = s_adr_o | (gnt_q[i] ? m_adr_i[i*ADR_W +: ADR_W] : '0);
        s_dat_o = s_dat_o | (gnt_q[i] ? m_dat_i[i*DAT_W +: DAT_W] : '0);
      end
    end else begin
      s_we_o  = 1'b0;
      s_adr_o = '0;
      s_dat_o = '0;
    end
  end

  // Return ack/err only to the granted master. An aborted cycle gets neither.
  always_comb begin
    m_ack_o = '0;
    m_err_o = '0;
    if (active_s && cyc_g_s) begin
      m_ack_o = gnt_q & {NUM_M{s_ack_i}};
      m_err_o = gnt_q & {NUM_M{tmo_s}};
    end else begin
      m_ack_o = '0;
      m_err_o = '0;
    end
  end

  assign m_dat_o  = s_dat_i;
  assign gnt_o    = gnt_q;
  assign busy_o   = (state_q == ST_ACTIVE) || (state_q == ST_RELEASE);
  assign s_cyc_o  = active_s;
  assign s_stb_o  = active_s;
  assign s_taga_o = ~active_s;

endmodule
